// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor; defining CLA_SATURATE_EN adds a Sat clamp input.
// Latency 2 cycles (operand/lookahead register, then result register), one result per cycle.
// Backpressure: results hold while out_ready=0; in_ready drops only when both stages are full.
module cla_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
`ifdef CLA_SATURATE_EN
  input  logic             Sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             G_star,
  output logic             P_star
);

  localparam int NGRP = WIDTH / 4;

  // Operand conditioning: subtraction is A + ~B + ~Cin
  logic [WIDTH-1:0] bx, g_in, p_in;
  logic             c0_in;
  logic [NGRP-1:0]  grp_g_in, grp_p_in;

  assign bx    = Sub ? ~B : B;
  assign c0_in = Sub ? ~Cin : Cin;
  assign g_in  = A & bx;
  assign p_in  = A ^ bx;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    assign grp_g_in[k] = g_in[4*k+3]
                       | (p_in[4*k+3] & g_in[4*k+2])
                       | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
                       | ((&p_in[4*k+1 +: 3]) & g_in[4*k]);
    assign grp_p_in[k] = &p_in[4*k +: 4];
  end

  logic s2_load;
  logic s1_valid;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic             s1_c0;
  logic [NGRP-1:0]  s1_gg, s1_pg;
`ifdef CLA_SATURATE_EN
  logic             s1_sat, s1_a_sign;
`endif

  assign s2_load  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | ~out_valid | out_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // Payload needs no reset: it is only consumed when s1_valid is set
  always_ff @(posedge Clk) begin
    if (in_valid && in_ready) begin
      s1_p  <= p_in;
      s1_g  <= g_in;
      s1_c0 <= c0_in;
      s1_gg <= grp_g_in;
      s1_pg <= grp_p_in;
`ifdef CLA_SATURATE_EN
      s1_sat    <= Sat;
      s1_a_sign <= A[WIDTH-1];
`endif
    end
  end

  // Group carries: each one is a flat sum-of-products over lower groups and c0
  logic [NGRP:0] gc;
  always_comb begin
    logic term;
    gc = '0;
    for (int k = 0; k <= NGRP; k++) begin
      term = s1_c0;
      for (int m = 0; m < k; m++) term = term & s1_pg[m];
      gc[k] = term;
      for (int j = 0; j < k; j++) begin
        term = s1_gg[j];
        for (int m = j + 1; m < k; m++) term = term & s1_pg[m];
        gc[k] = gc[k] | term;
      end
    end
  end

  logic [WIDTH-1:0] c;
  always_comb begin
    logic term, cv;
    c    = '0;
    term = 1'b0;
    cv   = 1'b0;
    for (int k = 0; k < NGRP; k++) begin
      for (int i = 0; i < 4; i++) begin
        term = gc[k];
        for (int m = 0; m < i; m++) term = term & s1_p[4*k+m];
        cv = term;
        for (int j = 0; j < i; j++) begin
          term = s1_g[4*k+j];
          for (int m = j + 1; m < i; m++) term = term & s1_p[4*k+m];
          cv = cv | term;
        end
        c[4*k+i] = cv;
      end
    end
  end

  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt, ovf_nxt, gs_nxt, ps_nxt;
  always_comb begin
    logic term;
    cout_nxt = gc[NGRP];
    ovf_nxt  = c[WIDTH-1] ^ gc[NGRP];
    sum_nxt  = s1_p ^ c;
`ifdef CLA_SATURATE_EN
    if (s1_sat && ovf_nxt) begin
      sum_nxt = s1_a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    gs_nxt = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      term = s1_gg[j];
      for (int m = j + 1; m < NGRP; m++) term = term & s1_pg[m];
      gs_nxt = gs_nxt | term;
    end
    ps_nxt = &s1_pg;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      G_star    <= 1'b0;
      P_star    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Sum    <= sum_nxt;
        Cout   <= cout_nxt;
        Ovf    <= ovf_nxt;
        G_star <= gs_nxt;
        P_star <= ps_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe at WIDTH=16; results are checked as they retire.
module tb_cla_adder_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic         cin_i = 1'b0, sub_i = 1'b0, sat = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [W-1:0] sum_o;
  logic         cout_o, ovf_o, gs_o, ps_o;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         gs;
    logic         ps;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cla_adder_pipe #(.WIDTH(W)) dut (
    .Clk(clk), .Rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_i), .B(b_i), .Cin(cin_i), .Sub(sub_i),
`ifdef CLA_SATURATE_EN
    .Sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .Sum(sum_o), .Cout(cout_o),
    .Ovf(ovf_o), .G_star(gs_o), .P_star(ps_o)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input logic s);
    logic [W-1:0] bx;
    logic [W:0]   full, gen;
    exp_t         e;
    bx     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub ? ~cin : cin)};
    gen    = {1'b0, a} + {1'b0, bx};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
    e.gs   = gen[W];
    e.ps   = ((a ^ bx) == {W{1'b1}});
    if (s && e.ovf) e.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return e;
  endfunction

  // Output monitor: a transfer seen before the edge is popped against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got Sum=%h Cout=%b, required no output", sum_o, cout_o);
      end else begin
        e_mon = sb.pop_front();
        if ({sum_o, cout_o, ovf_o, gs_o, ps_o} !== e_mon) begin
          n_fail++;
          $display("FAIL result got Sum=%h C=%b V=%b G=%b P=%b, required Sum=%h C=%b V=%b G=%b P=%b",
                   sum_o, cout_o, ovf_o, gs_o, ps_o,
                   e_mon.sum, e_mon.cout, e_mon.ovf, e_mon.gs, e_mon.ps);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    bit acc = 0;
    in_valid = 1'b1; a_i = a; b_i = b; cin_i = cin; sub_i = sub;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && !rst) begin
        acc = 1;
        sb.push_back(model(a, b, cin, sub, sat));
      end
      step();
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout got in_ready=%b, required 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic wait_drain;
    for (int t = 0; t < 100 && sb.size() != 0; t++) step();
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; a_i = 16'h1234; b_i = 16'h0001; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin rst = 1'b0; in_valid = 1'b0; end
      step();
      n_chk++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid cycle %0d got %b, required 0", i, out_valid);
      end
      n_chk++;
      if ({sum_o, cout_o, ovf_o, gs_o, ps_o} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got Sum=%h C=%b V=%b G=%b P=%b, required all 0",
                 i, sum_o, cout_o, ovf_o, gs_o, ps_o);
      end
    end
  endtask

  task automatic test_carry_chain;
    out_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early got out_valid=%b, required 0", out_valid);
    end
    step();
    n_chk++;
    if ({out_valid, sum_o, cout_o, ovf_o, gs_o, ps_o} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL carry_chain got V=%b Sum=%h C=%b O=%b G=%b P=%b, required 1 0000 1 0 1 0",
               out_valid, sum_o, cout_o, ovf_o, gs_o, ps_o);
    end
    wait_drain();
  endtask

  task automatic test_overflow_sub;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'hFFFF, 1'b0, 1'b0);
`ifdef CLA_SATURATE_EN
    sat = 1'b1;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    sat = 1'b0;
`endif
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_drain();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL overflow_sub_drain got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    fork
      begin
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        send(16'h0002, 16'h0002, 1'b0, 1'b0);
        send(16'h0003, 16'h0003, 1'b0, 1'b0);
      end
      begin
        for (int k = 1; k <= 4; k++) begin
          step();
          if (k >= 2) begin
            n_chk++;
            if ({out_valid, in_ready, sum_o} !== {1'b1, 1'b0, 16'h0002}) begin
              n_fail++;
              $display("FAIL stall_hold cycle %0d got V=%b in_ready=%b Sum=%h, required 1 0 0002",
                       k, out_valid, in_ready, sum_o);
            end
          end
        end
        out_ready = 1'b1;
        step();
        n_chk++;
        if ({out_valid, sum_o} !== {1'b1, 16'h0004}) begin
          n_fail++; $display("FAIL release_1 got V=%b Sum=%h, required 1 0004", out_valid, sum_o);
        end
        step();
        n_chk++;
        if ({out_valid, sum_o} !== {1'b1, 16'h0006}) begin
          n_fail++; $display("FAIL release_2 got V=%b Sum=%h, required 1 0006", out_valid, sum_o);
        end
      end
    join
    wait_drain();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL backpressure_drain got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    send(16'h0011, 16'h0022, 1'b0, 1'b0);
    send(16'h0033, 16'h0044, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    n_chk++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL midreset_flush got V=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (3) step();
    send(16'h0010, 16'h0020, 1'b0, 1'b0);
    step();
    n_chk++;
    if ({out_valid, sum_o} !== {1'b1, 16'h0030}) begin
      n_fail++; $display("FAIL post_reset got V=%b Sum=%h, required 1 0030", out_valid, sum_o);
    end
    wait_drain();
  endtask

  task automatic test_random;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) step();
        end
      end
      begin
        repeat (120) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL random_drain got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow_sub();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
